// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Eight-digit seven-segment scan controller. Holds a shadow bank
//             of eight 4-bit digits written over a valid/ready port, reloads
//             the active bank once per frame, and time-multiplexes the digits
//             with a dark blanking gap before every digit to avoid ghosting.
//  Options  : LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//             (index > 0) of the active bank are kept dark.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_valid,
   input  logic [2:0]  wr_addr,
   input  logic [3:0]  wr_data,
   output logic        wr_ready,
   input  logic [7:0]  digit_en,
   output logic [31:0] digits,
   output logic [2:0]  sel,
   output logic [7:0]  an,
   output logic        frame_start
);

   // One prescaler serves both phases, so it is sized for the longer one.
   localparam int C_MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int C_CW   = (C_MAXC > 1) ? $clog2(C_MAXC) : 1;

   localparam logic [C_CW-1:0] C_BLANK_LAST = C_CW'(BLANK_CYCLES - 1);
   localparam logic [C_CW-1:0] C_DRIVE_LAST = C_CW'(REFRESH_DIV - 1);

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   state_t            r_state;
   logic [C_CW-1:0]   r_cnt;
   logic [2:0]        r_sel;
   logic [7:0]        r_an;
   logic [31:0]       r_digits;
   logic [31:0]       r_shadow;
   logic              r_frame_start;
   logic              r_wr_ready;

   logic              w_wr_fire;
   logic              w_lz_blank;
   logic              w_lit;
   logic [7:0]        w_drive_an;

   assign w_wr_fire = wr_valid && r_wr_ready;

`ifdef LEADING_ZERO_BLANK_EN
   // w_upper_zero[i]: digit i and every higher digit of the active bank are 0.
   logic [7:0] w_upper_zero;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_upper_zero
         assign w_upper_zero[gi] = (r_digits[31:4*gi] == '0);
      end
   endgenerate

   // Digit 0 is always shown so an all-zero bank still reads "0".
   assign w_lz_blank = (r_sel != 3'd0) && w_upper_zero[r_sel];
`else
   assign w_lz_blank = 1'b0;
`endif

   // Anode pattern for the current digit while driving; digit_en is sampled
   // live so an enable change shows up on the next edge.
   assign w_lit      = digit_en[r_sel] & ~w_lz_blank;
   assign w_drive_an = ~({7'd0, w_lit} << r_sel);

   // Scan FSM, write port, frame reload and all registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_BLANK;
         r_cnt         <= '0;
         r_sel         <= 3'd0;
         r_an          <= 8'hFF;
         r_digits      <= '0;
         r_shadow      <= '0;
         r_frame_start <= 1'b0;
         r_wr_ready    <= 1'b0;
      end else begin
         r_wr_ready    <= 1'b1;
         r_frame_start <= 1'b0;

         // Shadow write; a reload on the same edge still sees the old value.
         if (w_wr_fire) begin
            r_shadow[4*wr_addr +: 4] <= wr_data;
         end

         case (r_state)
            ST_BLANK: begin
               if (r_cnt == C_BLANK_LAST) begin
                  r_state <= ST_DRIVE;
                  r_cnt   <= '0;
                  r_an    <= w_drive_an;
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_an    <= 8'hFF;
               end
            end
            ST_DRIVE: begin
               if (r_cnt == C_DRIVE_LAST) begin
                  // Select advances only while dark so the mux settles unseen.
                  r_state <= ST_BLANK;
                  r_cnt   <= '0;
                  r_an    <= 8'hFF;
                  r_sel   <= r_sel + 3'd1;
                  if (r_sel == 3'd7) begin
                     r_digits      <= r_shadow;
                     r_frame_start <= 1'b1;
                  end
               end else begin
                  r_cnt   <= r_cnt + 1'b1;
                  r_an    <= w_drive_an;
               end
            end
            default: begin
               r_state <= ST_BLANK;
               r_cnt   <= '0;
               r_an    <= 8'hFF;
            end
         endcase
      end
   end

   assign wr_ready    = r_wr_ready;
   assign digits      = r_digits;
   assign sel         = r_sel;
   assign an          = r_an;
   assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Self-checking bench for seg_scan_ctrl using a timeline model:
//             the scan position is derived from the edge count since reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

   localparam int R  = 4;
   localparam int B  = 2;
   localparam int SL = R + B;
   localparam int P  = 8 * SL;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        wr_valid = 1'b0;
   logic [2:0]  wr_addr = 3'd0;
   logic [3:0]  wr_data = 4'd0;
   logic [7:0]  digit_en = 8'hFF;
   logic        wr_ready;
   logic [31:0] digits;
   logic [2:0]  sel;
   logic [7:0]  an;
   logic        frame_start;

   seg_scan_ctrl #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ready(wr_ready), .digit_en(digit_en),
      .digits(digits), .sel(sel), .an(an), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Model state: k = clock edges since reset release.
   int         k;
   logic [3:0] m_sh [8];
   logic [3:0] m_dg [8];
   logic       m_ready;
   logic [7:0] m_an;
   int         checks = 0;
   int         failures = 0;

   function automatic logic [31:0] m_bank();
      logic [31:0] v = '0;
      for (int i = 0; i < 8; i++) v[4*i +: 4] = m_dg[i];
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s k=%0d got=%h expected=%h", nm, k, act, exp);
      end
   endtask

   task automatic model_reset();
      k = 0;
      m_ready = 1'b0;
      m_an = 8'hFF;
      for (int i = 0; i < 8; i++) begin m_sh[i] = 4'd0; m_dg[i] = 4'd0; end
   endtask

   // Advance the model across one edge using the inputs present at that edge.
   task automatic model_edge();
      logic acc;
      int   s, off;
      logic lit;
      acc = wr_valid && m_ready;
      k++;
      if (k % P == 0) for (int i = 0; i < 8; i++) m_dg[i] = m_sh[i];
      if (acc) m_sh[wr_addr] = wr_data;
      m_ready = 1'b1;
      s   = (k % P) / SL;
      off = (k % P) % SL;
      if (off < B) m_an = 8'hFF;
      else begin
         lit = digit_en[s];
`ifdef LEADING_ZERO_BLANK_EN
         if (s > 0) begin
            logic allz = 1'b1;
            for (int j = s; j < 8; j++) if (m_dg[j] != 4'd0) allz = 1'b0;
            if (allz) lit = 1'b0;
         end
`endif
         m_an = 8'hFF;
         if (lit) m_an[s] = 1'b0;
      end
   endtask

   task automatic compare();
      chk("an", {24'd0, an}, {24'd0, m_an});
      chk("sel", {29'd0, sel}, 32'((k % P) / SL));
      chk("digits", digits, m_bank());
      chk("frame_start", {31'd0, frame_start}, {31'd0, (k > 0) && (k % P == 0)});
      chk("wr_ready", {31'd0, wr_ready}, {31'd0, m_ready});
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic run_to(input int n);
      while (k < n) step();
   endtask

   task automatic wr(input logic [2:0] a, input logic [3:0] d);
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_valid = 1'b0;
   endtask

   // Assert reset asynchronously between edges, then release at a falling edge.
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_an", {24'd0, an}, 32'h0000_00FF);
      chk("rst_sel", {29'd0, sel}, 32'd0);
      chk("rst_digits", digits, 32'd0);
      chk("rst_fs", {31'd0, frame_start}, 32'd0);
      chk("rst_ready", {31'd0, wr_ready}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      #1 chk("rel_ready", {31'd0, wr_ready}, 32'd0);
   endtask

   task automatic frame_mask(output logic [7:0] m);
      m = 8'h00;
      repeat (P) begin
         step();
         m |= ~an;
      end
   endtask

   logic [7:0] mask;

   initial begin
      model_reset();
      #1 do_reset();

      // Startup sequence pinned with hand-computed values.
      step(); chk("t1_an_k1", {24'd0, an}, 32'h0000_00FF);
      step(); chk("t1_an_k2", {24'd0, an}, 32'h0000_00FE);
      run_to(6); chk("t1_an_k6", {24'd0, an}, 32'h0000_00FF);
      chk("t1_sel_k6", {29'd0, sel}, 32'd1);
      run_to(8); chk("t1_an_k8", {24'd0, an}, 32'h0000_00FD);
      run_to(48); chk("t1_sel_k48", {29'd0, sel}, 32'd0);
      chk("t1_fs_k48", {31'd0, frame_start}, 32'd1);

      // Mid-frame write is deferred to the reload.
      run_to(50); wr(3'd3, 4'hA);
      run_to(95); chk("t2_before", {28'd0, digits[15:12]}, 32'd0);
      step(); chk("t2_after", {28'd0, digits[15:12]}, 32'h0000_000A);
      chk("t2_fs", {31'd0, frame_start}, 32'd1);

      // Write on the reload edge, and back-to-back writes to one address.
      run_to(143); wr(3'd6, 4'h9);
      chk("t3_edge_absent", {28'd0, digits[27:24]}, 32'd0);
      wr(3'd5, 4'h1); wr(3'd5, 4'h2);
      run_to(192);
      chk("t3_next_present", {28'd0, digits[27:24]}, 32'h0000_0009);
      chk("t3_last_wins", {28'd0, digits[23:20]}, 32'h0000_0002);

      // Bank is 0,0,0,A,0,2,9,0 here; digit 3 disabled.
      digit_en = 8'hF7;
      frame_mask(mask);
`ifdef LEADING_ZERO_BLANK_EN
      chk("t4_lit", {24'd0, mask}, 32'h0000_0077);
`else
      chk("t4_lit", {24'd0, mask}, 32'h0000_00F7);
`endif
      digit_en = 8'hFF;

      // Asynchronous reset while driving digit 5.
      run_to(273);
      chk("t5_pre_sel", {29'd0, sel}, 32'd5);
      do_reset();
      step(); chk("t5_an_k1", {24'd0, an}, 32'h0000_00FF);
      step(); chk("t5_an_k2", {24'd0, an}, 32'h0000_00FE);

      // Leading-zero behaviour: bank 0x00000120, then all zero.
      wr(3'd0, 4'h0); wr(3'd1, 4'h2); wr(3'd2, 4'h1);
      run_to(P);
      chk("t6_bank", digits, 32'h0000_0120);
      frame_mask(mask);
`ifdef LEADING_ZERO_BLANK_EN
      chk("t6_lit_120", {24'd0, mask}, 32'h0000_0007);
`else
      chk("t6_lit_120", {24'd0, mask}, 32'h0000_00FF);
`endif
      wr(3'd1, 4'h0); wr(3'd2, 4'h0);
      run_to(3 * P);
      chk("t6_bank_zero", digits, 32'd0);
      frame_mask(mask);
`ifdef LEADING_ZERO_BLANK_EN
      chk("t6_lit_zero", {24'd0, mask}, 32'h0000_0001);
`else
      chk("t6_lit_zero", {24'd0, mask}, 32'h0000_00FF);
`endif

      // Randomized traffic against the timeline model.
      for (int i = 0; i < 800; i++) begin
         wr_valid = ($urandom_range(0, 1) == 1);
         wr_addr  = 3'($urandom_range(0, 7));
         wr_data  = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0)
            digit_en = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
         step();
      end
      wr_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
